// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and read-port packing helpers for regfile_mp.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 4;
  localparam int PC_IDX_DEFAULT = 2**ADDR_W_DEFAULT - 1;

  // Least significant bit of packed port 'port' in a bus of 'width'-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  // Extract one address field from a packed address bus (default geometry).
  function automatic logic [ADDR_W_DEFAULT-1:0] unpack_addr(
    input logic [3*ADDR_W_DEFAULT-1:0] bus, input int unsigned port);
    return bus[port_lsb(port, ADDR_W_DEFAULT) +: ADDR_W_DEFAULT];
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-load bit per register. A set and a clear to the
// same register in one cycle leave it set (back-to-back load to that register).
// The PC index is never marked pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int PC_IDX = PC_IDX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic                  set_ok_s;
  logic [NREG-1:0]       pending_nxt_s;

  assign set_ok_s = set_en && (set_addr != PC_A);

  // Next-state per bit: set has priority over clear, otherwise hold.
  always_comb begin
    pending_nxt_s = pending;
    for (int j = 0; j < NREG; j++) begin
      if (set_ok_s && (set_addr == ADDR_W'(j))) begin
        pending_nxt_s[j] = 1'b1;
      end else if (clr_en && (clr_addr == ADDR_W'(j))) begin
        pending_nxt_s[j] = 1'b0;
      end else begin
        pending_nxt_s[j] = pending[j];
      end
    end
  end

  // Pending vector register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt_s;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports (A: ALU, B: load /
// writeback, B wins on collision), NREAD combinational read ports, PC slot
// returning r15, and a pending-load scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN -- reads matching a write in the
// same cycle return the write data; a matching port-B write masks rd_busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int NREAD  = 3,
  parameter int PC_IDX = 2**ADDR_W - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  output logic [NREAD-1:0]        rd_busy,
  input  logic [DATA_W-1:0]       r15,
  input  logic                    we_a,
  input  logic [ADDR_W-1:0]       wa_a,
  input  logic [DATA_W-1:0]       wd_a,
  input  logic                    we_b,
  input  logic [ADDR_W-1:0]       wa_b,
  input  logic [DATA_W-1:0]       wd_b,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [2**ADDR_W-1:0]    pending
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  // The PC slot is never written, so it stays at its reset value and is
  // never selected by the read mux; only NREG-1 entries carry state.
  logic [DATA_W-1:0] store_r [NREG];
  logic [ADDR_W-1:0] raddr_s [NREAD];
  logic              wen_a_s;
  logic              wen_b_s;

  assign wen_a_s = we_a && (wa_a != PC_A);
  assign wen_b_s = we_b && (wa_b != PC_A);

  for (genvar i = 0; i < NREAD; i++) begin : g_raddr
    assign raddr_s[i] = ra[port_lsb(i, ADDR_W) +: ADDR_W];
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (iss_valid),
    .set_addr (iss_addr),
    .clr_en   (we_b),
    .clr_addr (wa_b),
    .pending  (pending)
  );

  // Register storage: port B overrides port A on the same index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NREG; j++) begin
        store_r[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NREG; j++) begin
        if (wen_b_s && (wa_b == ADDR_W'(j))) begin
          store_r[j] <= wd_b;
        end else if (wen_a_s && (wa_a == ADDR_W'(j))) begin
          store_r[j] <= wd_a;
        end else begin
          store_r[j] <= store_r[j];
        end
      end
    end
  end

  // Read mux: PC slot first, then optional same-cycle bypass, then storage.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (raddr_s[i] == PC_A) begin
        rd[port_lsb(i, DATA_W) +: DATA_W] = r15;
        rd_busy[i]                        = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (we_b && (wa_b == raddr_s[i])) begin
        rd[port_lsb(i, DATA_W) +: DATA_W] = wd_b;
        rd_busy[i]                        = 1'b0;
      end else if (we_a && (wa_a == raddr_s[i])) begin
        rd[port_lsb(i, DATA_W) +: DATA_W] = wd_a;
        rd_busy[i]                        = pending[raddr_s[i]];
      end
`endif
      else begin
        rd[port_lsb(i, DATA_W) +: DATA_W] = store_r[raddr_s[i]];
        rd_busy[i]                        = pending[raddr_s[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-driven bench for regfile_mp. Expected read results
// are pushed to a queue when the read is driven and popped when compared.
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NR   = 3;
  localparam int NREG = 16;
  localparam logic [AW-1:0] PC = 4'd15;

  logic             clk;
  logic             reset_n;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rd_busy;
  logic [DW-1:0]    r15;
  logic             we_a, we_b, iss_valid;
  logic [AW-1:0]    wa_a, wa_b, iss_addr;
  logic [DW-1:0]    wd_a, wd_b;
  logic [NREG-1:0]  pending;

  typedef struct {
    string      name;
    int         port;
    logic [DW-1:0] data;
    logic       busy;
  } exp_t;

  exp_t            expq[$];
  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_pend;
  int              checks;
  int              failures;

  regfile_mp dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .r15       (r15),
    .we_a      (we_a),
    .wa_a      (wa_a),
    .wd_a      (wd_a),
    .we_b      (we_b),
    .wa_b      (wa_b),
    .wd_b      (wd_b),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we_a = 1'b0; wa_a = 4'd0; wd_a = 32'd0;
    we_b = 1'b0; wa_b = 4'd0; wd_b = 32'd0;
    iss_valid = 1'b0; iss_addr = 4'd0;
  endtask

  task automatic model_clear();
    for (int j = 0; j < NREG; j++) m_mem[j] = 32'd0;
    m_pend = 16'd0;
  endtask

  // Apply current inputs to the model, then advance one rising edge.
  task automatic tick();
    if (we_a && wa_a != PC) m_mem[wa_a] = wd_a;
    if (we_b && wa_b != PC) m_mem[wa_b] = wd_b;
    if (we_b) m_pend[wa_b] = 1'b0;
    if (iss_valid && iss_addr != PC) m_pend[iss_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input int port, input logic [DW-1:0] d, input logic b);
    exp_t e;
    e.name = name; e.port = port; e.data = d; e.busy = b;
    expq.push_back(e);
  endtask

  // Drive a read address and push the model's prediction.
  task automatic drive_read(input string name, input int port, input logic [AW-1:0] a);
    logic [DW-1:0] d;
    logic          b;
    ra[port*AW +: AW] = a;
    if (a == PC) begin
      d = r15; b = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (we_b && wa_b == a) begin
      d = wd_b; b = 1'b0;
    end else if (we_a && wa_a == a) begin
      d = wd_a; b = m_pend[a];
    end
`endif
    else begin
      d = m_mem[a]; b = m_pend[a];
    end
    push_exp(name, port, d, b);
  endtask

  task automatic check_reads();
    exp_t e;
    #1;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s port%0d: got rd=%h busy=%b, want rd=%h busy=%b",
                 e.name, e.port, rd[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic check_pending(input string name);
    checks++;
    if (pending !== m_pend) begin
      failures++;
      $display("FAIL %s: got pending=%h, want %h", name, pending, m_pend);
    end
  endtask

  task automatic test_reset();
    idle();
    ra = '0;
    r15 = 32'h0000_0108;
    reset_n = 1'b0;
    model_clear();
    #12;
    check_pending("reset_pending_low");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < NREG; a++) begin
      if (a == 15) push_exp("reset_pc", a % NR, 32'h0000_0108, 1'b0);
      else         push_exp("reset_reg", a % NR, 32'd0, 1'b0);
      ra[(a % NR)*AW +: AW] = 4'(a);
      if ((a % NR) == NR-1 || a == NREG-1) check_reads();
    end
    check_pending("reset_pending");
  endtask

  task automatic test_same_addr();
    idle();
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hDEAD_BEEF;
    we_b = 1'b1; wa_b = 4'd3; wd_b = 32'h1234_5678;
    tick();
    idle();
    push_exp("b_wins_r3", 0, 32'h1234_5678, 1'b0);
    ra[0*AW +: AW] = 4'd3;
    check_reads();
  endtask

  task automatic test_pc_write();
    idle();
    r15 = 32'h0000_0040;
    we_a = 1'b1; wa_a = PC; wd_a = 32'hFFFF_FFFF;
    we_b = 1'b1; wa_b = PC; wd_b = 32'hFFFF_FFFF;
    tick();
    idle();
    push_exp("pc_read", 0, 32'h0000_0040, 1'b0);
    ra[0*AW +: AW] = PC;
    check_reads();
    for (int a = 0; a < 15; a++) begin
      drive_read("pc_write_no_side", 1, 4'(a));
      check_reads();
    end
  endtask

  task automatic test_load_pending();
    idle();
    iss_valid = 1'b1; iss_addr = 4'd5;
    tick();
    idle();
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (pending[5] !== 1'b1) begin
        failures++;
        $display("FAIL load_pending_c%0d: got %b, want 1", c, pending[5]);
      end
      tick();
    end
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h0000_00A5;
    ra[2*AW +: AW] = 4'd5;
`ifdef REGFILE_BYPASS_EN
    push_exp("load_wb_cycle", 2, 32'h0000_00A5, 1'b0);
`else
    push_exp("load_wb_cycle", 2, 32'h0000_0000, 1'b1);
`endif
    check_reads();
    checks++;
    if (pending[5] !== 1'b1) begin
      failures++;
      $display("FAIL load_pending_c3: got %b, want 1", pending[5]);
    end
    tick();
    idle();
    checks++;
    if (pending[5] !== 1'b0) begin
      failures++;
      $display("FAIL load_cleared: got %b, want 0", pending[5]);
    end
    push_exp("load_after", 2, 32'h0000_00A5, 1'b0);
    check_reads();
  endtask

  task automatic test_set_wins();
    idle();
    iss_valid = 1'b1; iss_addr = 4'd7;
    tick();
    iss_valid = 1'b1; iss_addr = 4'd7;
    we_b = 1'b1; wa_b = 4'd7; wd_b = 32'h0000_0077;
    tick();
    idle();
    checks++;
    if (pending[7] !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: got pending7=%b, want 1", pending[7]);
    end
    push_exp("set_wins_read", 1, 32'h0000_0077, 1'b1);
    ra[1*AW +: AW] = 4'd7;
    check_reads();
    iss_valid = 1'b1; iss_addr = PC;
    tick();
    idle();
    check_pending("iss_pc_ignored");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      we_a = 1'($urandom_range(0, 1)); wa_a = 4'($urandom_range(0, 15)); wd_a = $urandom;
      we_b = 1'($urandom_range(0, 1)); wa_b = 4'($urandom_range(0, 15)); wd_b = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_addr = 4'($urandom_range(0, 15));
      if (c % 4 == 0) wa_b = wa_a;
      if (c % 5 == 0) iss_addr = wa_b;
      r15 = $urandom;
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = 4'($urandom_range(0, 15));
        if (p == 0 && (c % 3 == 0)) a = wa_b;
        if (p == 1 && (c % 3 == 1)) a = wa_a;
        drive_read("b2b_read", p, a);
      end
      check_reads();
      check_pending("b2b_pending");
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    we_a = 1'b1; wa_a = 4'd1; wd_a = 32'h1111_1111;
    we_b = 1'b1; wa_b = 4'd2; wd_b = 32'h2222_2222;
    iss_valid = 1'b1; iss_addr = 4'd6;
    tick();
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h3333_3333;
    we_b = 1'b1; wa_b = 4'd4; wd_b = 32'h4444_4444;
    iss_valid = 1'b1; iss_addr = 4'd8;
    tick();
    idle();
    drive_read("pre_rst_r1", 0, 4'd1);
    drive_read("pre_rst_r2", 1, 4'd2);
    drive_read("pre_rst_r4", 2, 4'd4);
    check_reads();
    check_pending("pre_rst_pending");
    #2;
    reset_n = 1'b0;
    model_clear();
    drive_read("async_rst_r1", 0, 4'd1);
    drive_read("async_rst_r3", 1, 4'd3);
    drive_read("async_rst_pc", 2, PC);
    check_reads();
    check_pending("async_rst_pending");
    #1;
    reset_n = 1'b1;
    we_a = 1'b1; wa_a = 4'd2; wd_a = 32'h0000_0055;
    tick();
    idle();
    drive_read("post_rst_write", 0, 4'd2);
    drive_read("post_rst_r4", 1, 4'd4);
    check_reads();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_same_addr();
    test_pc_write();
    test_load_pending();
    test_set_wins();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
